hp_manager: RTL
===============

Name: hp_manager

Overview:
- Downstream of the win/lose arbiter. Consumes its registered 2-bit round-result code (00 none, 01 self wins, 10 enemy wins, 11 draw).
- Maintains hit points for both players, applies damage once per round result and detects game over.
- Drives the HP display and the game-result logic.

Parameters:
- HP_W, 4, width of each HP counter.
- HP_INIT, 5, HP loaded at reset and at game start; must be ≤ 2^HP_W−1.
- DAMAGE, 1, HP removed from the losing side per round (both sides on draw).
- LOCK_CYC, 8, lockout length in cycles after an applied result (used only with HP_LOCKOUT_EN).

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- START  input  1  one-cycle pulse from game control; begins or restarts a game.
- WL_IN  input  2  round-result code from the win/lose arbiter.
- MY_HP  output  HP_W  own remaining HP.
- EN_HP  output  HP_W  enemy remaining HP.
- HIT  output  2  one-cycle damage strobe: bit0 enemy damaged, bit1 self damaged.
- GAME_OVER  output  1  high while in OVER state.
- RESULT  output  2  final outcome, valid while GAME_OVER: 01 self wins, 10 enemy wins, 11 draw, 00 otherwise.

Behaviour:
- One clock CLK; reset RST is synchronous and active-high. Every register resets on a CLK edge with RST=1.
- Reset values: state=IDLE, MY_HP=EN_HP=HP_INIT, HIT=00, GAME_OVER=0, RESULT=00, armed flag=1, lockout counter=0.
- FSM has three states:
  - IDLE: HP held at HP_INIT. On START go to PLAY; HP is reloaded and armed set to 1.
  - PLAY: applies results as defined below. On the cycle any HP reaches 0, go to OVER.
  - OVER: GAME_OVER=1 and RESULT is held. WL_IN is ignored. On START, reload HP, clear RESULT and go to PLAY.
- START in PLAY restarts the game: HP is reloaded, RESULT stays 00 and HIT=00 that cycle. START takes priority over a simultaneous WL_IN event.
- Event detection (PLAY only):
  - A result is applied when WL_IN≠00 and armed=1. Armed is then cleared.
  - Armed is set again only after a cycle with WL_IN=00. A level held for many cycles therefore counts once.
  - A direct nonzero-to-nonzero change of WL_IN (e.g. 01→11) is not a new event.
- Damage:
  - 01 → EN_HP −= DAMAGE.
  - 10 → MY_HP −= DAMAGE.
  - 11 → both −= DAMAGE.
  - Subtraction saturates at 0; there is no wrap-around.
- HIT is asserted on the same edge that updates HP (one cycle after WL_IN is sampled) and is 00 on every other cycle.
- Game-over decode on the updating edge, using the new HP values:
  - Both 0 → RESULT=11.
  - EN_HP 0 only → 01.
  - MY_HP 0 only → 10.
  - GAME_OVER rises on that same edge.
- Latency: WL_IN event → HP/HIT/GAME_OVER updated 1 cycle later.
- Reset mid-game aborts immediately to IDLE with reset values; no pending event survives.

Optional Feature:
- Macro HP_LOCKOUT_EN.
- Defined:
  - After each applied result, a counter loads LOCK_CYC and decrements each cycle.
  - While it is nonzero, events are ignored even if armed; arming still tracks WL_IN=00.
  - START and RST clear the counter.
- Undefined: no counter logic exists; the only gating is the armed flag.

Decomposition:
- Shared package holds:
  - the WL code constants (WL_NONE=00, WL_SELF=01, WL_ENEMY=10, WL_DRAW=11), also used by the arbiter;
  - the FSM state encoding (IDLE, PLAY, OVER);
  - the RESULT encoding.
- One natural sub-module, hp_counter: one saturating down-counter with load value, load strobe and decrement strobe, instantiated twice (self and enemy).
- FSM, arming and the optional lockout counter live in hp_manager.

Test Plan:
1. Reset, START, WL_IN=01 held 5 cycles then 00 → EN_HP 5→4 once, HIT=01 for one cycle, MY_HP=5.
2. Defaults, five separate 10 pulses each separated by 00 → MY_HP 5→0, GAME_OVER=1 and RESULT=10 on the fifth update edge; later WL_IN=01 leaves EN_HP=5.
3. Both at 1, WL_IN=11 → both 0, HIT=11, RESULT=11. With DAMAGE=3 and HP=2, the result saturates at 0 with no wrap.
4. WL_IN 01→11 with no 00 between → only the 01 is applied. START coincident with WL_IN=10 in PLAY → HP reloaded to 5, HIT=00.
5. RST mid-game with MY_HP=2 → next cycle IDLE, MY_HP=EN_HP=5, GAME_OVER=0. In OVER, START → PLAY with RESULT=00.
6. With HP_LOCKOUT_EN and LOCK_CYC=8: 01, 00, then 01 within 8 cycles → second event ignored (EN_HP=4); the same 01 after 8 cycles → EN_HP=3.

Source files
------------

// File: rtl/hp_manager_pkg.sv
// -----------------------------------------------------------------------------
// hp_manager_pkg
// Shared definitions for the hit-point manager and its neighbours:
//   - WL_*  : round-result codes produced by the win/lose arbiter
//   - state_t : hp_manager FSM state encoding (IDLE, PLAY, OVER)
//   - RES_* : final game outcome encoding driven on RESULT
//   - decode_result() : maps "which side reached zero" to a RES_* code
// -----------------------------------------------------------------------------
package hp_manager_pkg;

    localparam logic [1:0] WL_NONE  = 2'b00;
    localparam logic [1:0] WL_SELF  = 2'b01;
    localparam logic [1:0] WL_ENEMY = 2'b10;
    localparam logic [1:0] WL_DRAW  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    localparam logic [1:0] RES_NONE  = 2'b00;
    localparam logic [1:0] RES_SELF  = 2'b01;
    localparam logic [1:0] RES_ENEMY = 2'b10;
    localparam logic [1:0] RES_DRAW  = 2'b11;

    // my_zero: own HP reached 0; en_zero: enemy HP reached 0.
    function automatic logic [1:0] decode_result(input logic my_zero, input logic en_zero);
        if (my_zero && en_zero) return RES_DRAW;
        if (en_zero)            return RES_SELF;
        if (my_zero)            return RES_ENEMY;
        return RES_NONE;
    endfunction

endpackage

// File: rtl/hp_manager_if.sv
// -----------------------------------------------------------------------------
// hp_if
// Bundle between game control / display logic and hp_manager.
//   START     : one-cycle pulse, begins or restarts a game
//   WL_IN     : round-result code from the win/lose arbiter
//   MY_HP     : own remaining HP
//   EN_HP     : enemy remaining HP
//   HIT       : one-cycle damage strobe (bit0 enemy hit, bit1 self hit)
//   GAME_OVER : high while the game is over
//   RESULT    : final outcome, valid while GAME_OVER
// Modports: master = game control side, slave = hp_manager.
// -----------------------------------------------------------------------------
interface hp_if #(
    parameter int HP_W = 4
);
    logic            START;
    logic [1:0]      WL_IN;
    logic [HP_W-1:0] MY_HP;
    logic [HP_W-1:0] EN_HP;
    logic [1:0]      HIT;
    logic            GAME_OVER;
    logic [1:0]      RESULT;

    modport master (
        output START, WL_IN,
        input  MY_HP, EN_HP, HIT, GAME_OVER, RESULT
    );

    modport slave (
        input  START, WL_IN,
        output MY_HP, EN_HP, HIT, GAME_OVER, RESULT
    );
endinterface

// File: rtl/hp_manager_counter.sv
// -----------------------------------------------------------------------------
// hp_counter
// One saturating hit-point down-counter.
//   clk, rst  : clock, synchronous active-high reset (loads HP_INIT)
//   load      : reload HP_INIT (wins over dec)
//   dec       : subtract DAMAGE, saturating at zero
//   cnt       : registered count
//   cnt_next  : value the counter takes on the next edge, so the parent can
//               decode game over on the same edge that updates the count
// -----------------------------------------------------------------------------
module hp_counter #(
    parameter int HP_W    = 4,
    parameter int HP_INIT = 5,
    parameter int DAMAGE  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            dec,
    output logic [HP_W-1:0] cnt,
    output logic [HP_W-1:0] cnt_next
);

    logic [HP_W-1:0] cnt_q, cnt_d;

    // Damage larger than the remaining HP clamps to zero instead of wrapping.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a);
        if (int'(a) <= DAMAGE) return '0;
        return a - HP_W'(DAMAGE);
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (load)     cnt_d = HP_W'(HP_INIT);
        else if (dec) cnt_d = sat_sub(cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= HP_W'(HP_INIT);
        else     cnt_q <= cnt_d;
    end

    assign cnt      = cnt_q;
    assign cnt_next = cnt_d;

endmodule

// File: rtl/hp_manager.sv
// -----------------------------------------------------------------------------
// hp_manager
// Tracks both players' hit points, applies damage once per round result from
// the win/lose arbiter and detects game over.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : hp_if.slave (START, WL_IN in; MY_HP, EN_HP, HIT, GAME_OVER,
//              RESULT out)
// Optional build macro HP_LOCKOUT_EN: after each applied result a counter of
// LOCK_CYC cycles blocks further events. Without it only the armed flag gates
// events.
// -----------------------------------------------------------------------------
module hp_manager
    import hp_manager_pkg::*;
#(
    parameter int HP_W     = 4,
    parameter int HP_INIT  = 5,
    parameter int DAMAGE   = 1,
    parameter int LOCK_CYC = 8
) (
    input  logic CLK,
    input  logic RST,
    hp_if.slave  bus
);

    if (HP_INIT > (2 ** HP_W) - 1 || LOCK_CYC < 1) begin : g_param_check
        $error("hp_manager: HP_INIT must fit in HP_W bits and LOCK_CYC must be >= 1");
    end

    state_t     state_q, state_d;
    logic       armed_q, armed_d;
    logic [1:0] hit_q, hit_d;
    logic [1:0] result_q, result_d;
    logic       over_q, over_d;

    logic            ev_apply;
    logic            lock_free;
    logic            dec_my, dec_en;
    logic [HP_W-1:0] my_hp, en_hp, my_next, en_next;

`ifdef HP_LOCKOUT_EN
    localparam int LK_W = $clog2(LOCK_CYC + 1);

    logic [LK_W-1:0] lock_q, lock_d;

    always_comb begin
        lock_d = lock_q;
        if (bus.START)        lock_d = '0;
        else if (ev_apply)    lock_d = LK_W'(LOCK_CYC);
        else if (lock_q != '0) lock_d = lock_q - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) lock_q <= '0;
        else     lock_q <= lock_d;
    end

    assign lock_free = (lock_q == '0);
`else
    assign lock_free = 1'b1;
`endif

    // START outranks a coincident result, so the event is suppressed then.
    assign ev_apply = (state_q == ST_PLAY) && !bus.START && armed_q &&
                      (bus.WL_IN != WL_NONE) && lock_free;
    assign dec_en   = ev_apply && bus.WL_IN[0];
    assign dec_my   = ev_apply && bus.WL_IN[1];

    hp_counter #(.HP_W(HP_W), .HP_INIT(HP_INIT), .DAMAGE(DAMAGE)) u_my_hp (
        .clk      (CLK),
        .rst      (RST),
        .load     (bus.START),
        .dec      (dec_my),
        .cnt      (my_hp),
        .cnt_next (my_next)
    );

    hp_counter #(.HP_W(HP_W), .HP_INIT(HP_INIT), .DAMAGE(DAMAGE)) u_en_hp (
        .clk      (CLK),
        .rst      (RST),
        .load     (bus.START),
        .dec      (dec_en),
        .cnt      (en_hp),
        .cnt_next (en_next)
    );

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        result_d = result_q;
        over_d   = over_q;
        // WL code bits line up with HIT bits (bit0 enemy, bit1 self).
        hit_d    = ev_apply ? bus.WL_IN : 2'b00;

        // A quiet cycle re-arms, so a held level counts only once.
        if (bus.WL_IN == WL_NONE) armed_d = 1'b1;

        if (bus.START) begin
            state_d  = ST_PLAY;
            armed_d  = 1'b1;
            result_d = RES_NONE;
            over_d   = 1'b0;
        end else if (ev_apply) begin
            armed_d = 1'b0;
            if (my_next == '0 || en_next == '0) begin
                state_d  = ST_OVER;
                over_d   = 1'b1;
                result_d = decode_result(my_next == '0, en_next == '0);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            armed_q  <= 1'b1;
            hit_q    <= 2'b00;
            result_q <= RES_NONE;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            hit_q    <= hit_d;
            result_q <= result_d;
            over_q   <= over_d;
        end
    end

    assign bus.MY_HP     = my_hp;
    assign bus.EN_HP     = en_hp;
    assign bus.HIT       = hit_q;
    assign bus.GAME_OVER = over_q;
    assign bus.RESULT    = result_q;

endmodule
